// File: rtl/xnor_parity_rx_if.sv
// Serial link bundle for xnor_parity_rx: rx pin in, decoded word and status out.
// With XNOR_PARITY_RX_ERRCNT_EN defined the bundle also carries err_count.
interface xnor_parity_rx_if #(
    parameter int unsigned DATA_BITS = 4
);
    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 out_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;
`ifdef XNOR_PARITY_RX_ERRCNT_EN
    logic [7:0]           err_count;

    modport master (output rx, input data_out, out_valid, parity_err, frame_err, busy, err_count);
    modport slave  (input rx, output data_out, out_valid, parity_err, frame_err, busy, err_count);
`else
    modport master (output rx, input data_out, out_valid, parity_err, frame_err, busy);
    modport slave  (input rx, output data_out, out_valid, parity_err, frame_err, busy);
`endif
endinterface

// File: rtl/xnor_parity_rx.sv
// XNOR-parity frame receiver: start, DATA_BITS data LSB-first, parity, stop; mid-bit sampling.
// Optional XNOR_PARITY_RX_ERRCNT_EN adds a saturating 8-bit error counter on bus.err_count.
module xnor_parity_rx #(
    parameter int unsigned DATA_BITS    = 4,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    xnor_parity_rx_if.slave bus
);
    localparam int unsigned TMR_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    state_t               state, state_nx;
    logic [TMR_W-1:0]     timer;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 p_bit;
    logic                 strobe_pend;
    logic                 timer_clr, data_smp, par_smp, stop_smp;
    logic                 full_bit, half_bit;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Timer is cleared on every state change so each wait starts from zero.
    always_comb begin
        state_nx  = state;
        timer_clr = 1'b0;
        data_smp  = 1'b0;
        par_smp   = 1'b0;
        stop_smp  = 1'b0;
        full_bit  = (timer == TMR_W'(CLKS_PER_BIT - 1));
        half_bit  = (timer == TMR_W'(CLKS_PER_BIT / 2 - 1));
        case (state)
            IDLE: begin
                timer_clr = 1'b1;
                if (!bus.rx) state_nx = START;
            end
            START: begin
                if (half_bit) begin
                    timer_clr = 1'b1;
                    state_nx  = bus.rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (full_bit) begin
                    timer_clr = 1'b1;
                    data_smp  = 1'b1;
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) state_nx = PARITY;
                end
            end
            PARITY: begin
                if (full_bit) begin
                    timer_clr = 1'b1;
                    par_smp   = 1'b1;
                    state_nx  = STOP;
                end
            end
            STOP: begin
                if (full_bit) begin
                    timer_clr = 1'b1;
                    stop_smp  = 1'b1;
                    state_nx  = bus.rx ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                timer_clr = 1'b1;
                if (bus.rx) state_nx = IDLE;
            end
            default: begin
                timer_clr = 1'b1;
                state_nx  = IDLE;
            end
        endcase
    end

    // Datapath: bit capture, result registers and the delayed valid strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer          <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            p_bit          <= 1'b0;
            strobe_pend    <= 1'b0;
            bus.data_out   <= '0;
            bus.out_valid  <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            timer <= timer_clr ? '0 : timer + TMR_W'(1);
            if (state != DATA)
                bit_cnt <= '0;
            else if (data_smp && (bit_cnt != BIT_W'(DATA_BITS - 1)))
                bit_cnt <= bit_cnt + BIT_W'(1);
            if (data_smp) shreg[bit_cnt] <= bus.rx;
            if (par_smp)  p_bit <= bus.rx;
            if (stop_smp) begin
                bus.data_out   <= shreg;
                bus.parity_err <= ~((^shreg) ^ p_bit);
                bus.frame_err  <= ~bus.rx;
            end
            strobe_pend   <= stop_smp;
            bus.out_valid <= strobe_pend;
            bus.busy      <= (state_nx != IDLE);
        end
    end

`ifdef XNOR_PARITY_RX_ERRCNT_EN
    // Counts errored strobes, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (rst)
            bus.err_count <= '0;
        else if (bus.out_valid && (bus.parity_err || bus.frame_err) && (bus.err_count != 8'hFF))
            bus.err_count <= bus.err_count + 8'd1;
    end
`endif

endmodule
